// File: rtl/instr_fetch.sv
// Instruction fetch unit: credit-limited request issue toward instruction
// memory, an in-order response buffer of DEPTH entries presented to decode,
// and redirect handling that flushes the buffer and discards responses to
// requests still in flight.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned redirect
// raises a sticky misalign_fault and stops fetching until reset).
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic        misalign_fault
`endif
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(DEPTH);

   logic [31:0]   fetch_pc;
   logic [31:0]   rsp_pc;
   logic [CW-1:0] occ;
   logic [CW-1:0] outst;
   logic [CW-1:0] disc;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [31:0]   ibuf_data [DEPTH];
   logic [31:0]   ibuf_pc   [DEPTH];

   logic          fault;
   logic          accept;
   logic          rsp_in;
   logic          keep;
   logic          pop;
   logic [31:0]   target;
   logic [CW:0]   credit_used;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   assign inst_valid    = (occ != '0);
   assign inst          = inst_valid ? ibuf_data[head] : '0;
   assign inst_pc       = inst_valid ? ibuf_pc[head]   : '0;
   assign imem_req_addr = fetch_pc;

   // Credit check, handshakes and response keep/drop decision.
   // A pop this cycle frees a slot early: a response to a request issued now
   // cannot arrive before the next edge, by which time the slot is free.
   always_comb begin
`ifdef FETCH_MISALIGN_CHECK_EN
      target = redirect_pc;
`else
      target = redirect_pc & 32'hFFFF_FFFC;
`endif
      pop            = inst_valid & inst_ready & ~redirect_valid;
      credit_used    = {1'b0, outst} + {1'b0, occ} - {{CW{1'b0}}, pop};
      imem_req_valid = ~rst & ~redirect_valid & ~fault & (credit_used < DEPTH_C);
      accept         = imem_req_valid & imem_req_ready;
      rsp_in         = imem_rsp_valid & ~rst;
      keep           = rsp_in & ~redirect_valid & (disc == '0);
   end

   // Control state: PCs, occupancy, in-flight and discard counters, pointers.
   // On redirect every request still unanswered after this cycle is marked
   // for discard; that count already includes any earlier pending discards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         rsp_pc   <= RESET_PC;
         occ      <= '0;
         outst    <= '0;
         disc     <= '0;
         head     <= '0;
         tail     <= '0;
      end else begin
         outst <= outst + CW'(accept) - CW'(rsp_in);
         if (redirect_valid) begin
            fetch_pc <= target;
            rsp_pc   <= target;
            occ      <= '0;
            head     <= '0;
            tail     <= '0;
            disc     <= outst - CW'(rsp_in);
         end else begin
            if (accept) fetch_pc <= fetch_pc + 32'd4;
            if (keep) begin
               rsp_pc <= rsp_pc + 32'd4;
               tail   <= ptr_next(tail);
            end
            if (pop) head <= ptr_next(head);
            occ <= occ + CW'(keep) - CW'(pop);
            if (rsp_in && (disc != '0)) disc <= disc - CW'(1);
         end
      end
   end

   // Buffer storage: data and PC written at the tail on every kept response.
   always_ff @(posedge clk) begin
      if (keep) begin
         ibuf_data[tail] <= imem_rsp_data;
         ibuf_pc[tail]   <= rsp_pc;
      end
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   // Sticky fault on a misaligned redirect target; cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault <= 1'b0;
      end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
         fault <= 1'b1;
      end
   end

   assign misalign_fault = fault;
`else
   assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch (default DEPTH=2, RESET_PC=0) with an
// in-order, 1-cycle-latency instruction memory model that can be held off.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        misalign_fault;
`endif

   int errors = 0;
   int checks = 0;

   logic        mem_hold;
   logic [31:0] q[$];
   logic [31:0] dpc[$];
   logic [31:0] dinst[$];
   int          acc_cnt;

   instr_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
      ,
      .misalign_fault (misalign_fault)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   // Memory model and delivery monitor: responses one cycle after acceptance.
   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      acc_cnt        = 0;
      forever begin
         @(posedge clk);
         #2;
         if (!mem_hold && q.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mk(q.pop_front());
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
         end
         @(negedge clk);
         if (rst) begin
            q.delete();
            dpc.delete();
            dinst.delete();
            acc_cnt = 0;
         end else begin
            if (imem_req_valid && imem_req_ready) begin
               q.push_back(imem_req_addr);
               acc_cnt++;
            end
            if (inst_valid && inst_ready && !redirect_valid) begin
               dpc.push_back(inst_pc);
               dinst.push_back(inst);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      mem_hold       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      mem_hold       = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid);
      end
      checks++;
      if (inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_inst_valid: got %b expected 0", inst_valid);
      end
      checks++;
      if (inst !== 32'h0) begin
         errors++;
         $display("FAIL reset_inst: got %h expected 00000000", inst);
      end
      checks++;
      if (inst_pc !== 32'h0) begin
         errors++;
         $display("FAIL reset_inst_pc: got %h expected 00000000", inst_pc);
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      checks++;
      if (misalign_fault !== 1'b0) begin
         errors++;
         $display("FAIL reset_fault: got %b expected 0", misalign_fault);
      end
`endif
   endtask

   task automatic test_stream();
      logic [31:0] exp_pc;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checks++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * k)) begin
            errors++;
            $display("FAIL stream_req cyc%0d: got v=%b addr=%h expected v=1 addr=%h",
                     k, imem_req_valid, imem_req_addr, 32'(4 * k));
         end
         checks++;
         if (inst_valid !== (k >= 2)) begin
            errors++;
            $display("FAIL stream_inst_valid cyc%0d: got %b expected %b", k, inst_valid, (k >= 2));
         end
         if (k >= 2) begin
            exp_pc = 32'(4 * (k - 2));
            checks++;
            if (inst_pc !== exp_pc || inst !== mk(exp_pc)) begin
               errors++;
               $display("FAIL stream_inst cyc%0d: got pc=%h inst=%h expected pc=%h inst=%h",
                        k, inst_pc, inst, exp_pc, mk(exp_pc));
            end
         end
         step();
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      inst_ready = 1'b0;
      repeat (10) step();
      @(negedge clk);
      checks++;
      if (acc_cnt !== 2) begin
         errors++;
         $display("FAIL bp_accepted: got %0d expected 2", acc_cnt);
      end
      checks++;
      if (imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_req_valid: got %b expected 0", imem_req_valid);
      end
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== mk(32'h0)) begin
         errors++;
         $display("FAIL bp_head: got v=%b pc=%h inst=%h expected v=1 pc=00000000 inst=%h",
                  inst_valid, inst_pc, inst, mk(32'h0));
      end
      step();
      inst_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
         errors++;
         $display("FAIL bp_resume_req: got v=%b addr=%h expected v=1 addr=00000008",
                  imem_req_valid, imem_req_addr);
      end
      step();
      @(negedge clk);
      checks++;
      if (inst_pc !== 32'h4) begin
         errors++;
         $display("FAIL bp_second_head: got %h expected 00000004", inst_pc);
      end
   endtask

   task automatic test_req_stall();
      do_reset();
      step();
      step();
      imem_req_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
            errors++;
            $display("FAIL stall_hold cyc%0d: got v=%b addr=%h expected v=1 addr=00000008",
                     k, imem_req_valid, imem_req_addr);
         end
         step();
      end
      imem_req_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (imem_req_addr !== 32'h8) begin
         errors++;
         $display("FAIL stall_release: got %h expected 00000008", imem_req_addr);
      end
      step();
      @(negedge clk);
      checks++;
      if (imem_req_addr !== 32'hC) begin
         errors++;
         $display("FAIL stall_advance: got %h expected 0000000c", imem_req_addr);
      end
   endtask

   task automatic test_redirect();
      int stale;
      do_reset();
      mem_hold = 1'b1;
      step();
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      @(negedge clk);
      checks++;
      if (imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL redir_no_req: got %b expected 0", imem_req_valid);
      end
      step();
      redirect_valid = 1'b0;
      mem_hold       = 1'b0;
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL redir_flush: got inst_valid=%b req_valid=%b expected 0 0",
                  inst_valid, imem_req_valid);
      end
      step();
      @(negedge clk);
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
         errors++;
         $display("FAIL redir_req: got v=%b addr=%h expected v=1 addr=00000100",
                  imem_req_valid, imem_req_addr);
      end
      repeat (8) step();
      checks++;
      if (dpc.size() < 2) begin
         errors++;
         $display("FAIL redir_count: got %0d deliveries expected at least 2", dpc.size());
      end else begin
         checks++;
         if (dpc[0] !== 32'h100 || dinst[0] !== mk(32'h100)) begin
            errors++;
            $display("FAIL redir_first: got pc=%h inst=%h expected pc=00000100 inst=%h",
                     dpc[0], dinst[0], mk(32'h100));
         end
         checks++;
         if (dpc[1] !== 32'h104) begin
            errors++;
            $display("FAIL redir_second: got %h expected 00000104", dpc[1]);
         end
      end
      stale = 0;
      foreach (dpc[i]) if (dpc[i] < 32'h100) stale++;
      checks++;
      if (stale !== 0) begin
         errors++;
         $display("FAIL redir_stale: got %0d stale deliveries expected 0", stale);
      end
   endtask

   task automatic test_wrap();
      int base;
      do_reset();
      repeat (3) step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      base = dpc.size();
      repeat (8) step();
      checks++;
      if (dpc.size() < base + 3) begin
         errors++;
         $display("FAIL wrap_count: got %0d deliveries expected at least %0d", dpc.size(), base + 3);
      end else begin
         checks++;
         if (dpc[base] !== 32'hFFFF_FFFC || dinst[base] !== mk(32'hFFFF_FFFC)) begin
            errors++;
            $display("FAIL wrap_first: got pc=%h inst=%h expected pc=fffffffc inst=%h",
                     dpc[base], dinst[base], mk(32'hFFFF_FFFC));
         end
         checks++;
         if (dpc[base + 1] !== 32'h0 || dinst[base + 1] !== mk(32'h0)) begin
            errors++;
            $display("FAIL wrap_second: got pc=%h expected 00000000", dpc[base + 1]);
         end
         checks++;
         if (dpc[base + 2] !== 32'h4) begin
            errors++;
            $display("FAIL wrap_third: got pc=%h expected 00000004", dpc[base + 2]);
         end
      end
   endtask

   task automatic test_misalign();
`ifdef FETCH_MISALIGN_CHECK_EN
      do_reset();
      step();
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h102;
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (misalign_fault !== 1'b1 || imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL misalign_set: got fault=%b req_valid=%b expected 1 0",
                  misalign_fault, imem_req_valid);
      end
      repeat (5) step();
      @(negedge clk);
      checks++;
      if (misalign_fault !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL misalign_sticky: got fault=%b req_valid=%b inst_valid=%b expected 1 0 0",
                  misalign_fault, imem_req_valid, inst_valid);
      end
      do_reset();
      @(negedge clk);
      checks++;
      if (misalign_fault !== 1'b0 || imem_req_valid !== 1'b1) begin
         errors++;
         $display("FAIL misalign_clear: got fault=%b req_valid=%b expected 0 1",
                  misalign_fault, imem_req_valid);
      end
`else
      int base;
      do_reset();
      step();
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h102;
      step();
      redirect_valid = 1'b0;
      base = dpc.size();
      @(negedge clk);
      checks++;
      if (imem_req_addr !== 32'h100) begin
         errors++;
         $display("FAIL align_req: got %h expected 00000100", imem_req_addr);
      end
      repeat (6) step();
      checks++;
      if (dpc.size() <= base || dpc[base] !== 32'h100) begin
         errors++;
         $display("FAIL align_first: got %0d deliveries, first pc=%h expected 00000100",
                  dpc.size() - base, (dpc.size() > base) ? dpc[base] : 32'hx);
      end
`endif
   endtask

   initial begin
      rst            = 1'b0;
      imem_req_ready = 1'b0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      mem_hold       = 1'b0;
      #1;
      test_reset();
      test_stream();
      test_backpressure();
      test_req_stall();
      test_redirect();
      test_wrap();
      test_misalign();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
